fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the single-cycle-latency instruction memory of the MIPS core. Owns the program counter, issues word reads to instruction memory, buffers returned words with their PCs in a 2-entry queue, and presents them to decode over a valid/ready handshake. Handles redirects from branches and jumps, a halt request, and out-of-range or misaligned fetch faults.

---
 rtl/fetch_pkg.sv | 37 +++
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_buf.sv | 56 +++++
 rtl/fetch_ctrl.sv | 96 +++++++++
 tb/tb_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its
// consumers in decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_DEPTH = 32;

  // MIPS instruction field boundaries, shared with decode.
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the instruction-memory, decode handshake and redirect/halt
// signals around the fetch sequencer.
interface fetch_if;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  modport master (
    output imem_addr, imem_rd, inst_valid, inst_out, inst_pc, fetch_fault,
    input  imem_data, inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_addr, imem_rd, inst_valid, inst_out, inst_pc, fetch_fault,
    output imem_data, inst_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_buf.sv
// Two-entry in-order queue of fetched words. The head register is slot 0, so
// an emptied queue keeps presenting the last word it held.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot1;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head  <= slot1;
            slot1 <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The credit scheme upstream must never let a word arrive with no room.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == 2'd2)));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, credit-based issue to a one-cycle memory,
// in-flight tagging, redirect/halt/fault control and the decode-side queue.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH) << 2;

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  tag, tag_n;
  logic         inflight;
  logic         kill;
  logic         fault_q;

  logic [1:0]   occ;
  fetch_entry_t head;
  fetch_entry_t entry;
  logic [2:0]   load;
  logic         pop, push, can_try, issue;

  assign pop   = (occ != 2'd0) && bus.inst_ready;
  assign load  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign entry = '{inst: bus.imem_data, pc: tag};

  // A redirect drops whatever response lands in its own cycle (via flush) and
  // the kill flag guards the cycle after, so no pre-redirect word can enter.
  assign push  = inflight && !kill && !bus.redirect_valid;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tag_n   = tag;
    can_try = !bus.redirect_valid && (state != FAULT) && !bus.halt && (load < 3'd2);
    issue   = can_try && pc_legal(pc, PC_LIMIT);

    if (bus.redirect_valid) begin
      pc_n = bus.redirect_pc;
      if (!pc_legal(bus.redirect_pc, PC_LIMIT)) state_n = FAULT;
      else if (bus.halt)                        state_n = HALT;
      else                                      state_n = RUN;
    end else if (state != FAULT) begin
      if (can_try && !issue) state_n = FAULT;
      else if (bus.halt)     state_n = HALT;
      else                   state_n = RUN;
      if (issue) begin
        pc_n  = pc + 32'd4;
        tag_n = pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      tag      <= tag_n;
      inflight <= issue;
      kill     <= bus.redirect_valid;
      fault_q  <= (state_n == FAULT);
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (entry),
    .head  (head),
    .count (occ)
  );

  assign bus.imem_addr   = pc;
  assign bus.imem_rd     = issue && !rst;
  assign bus.inst_valid  = (occ != 2'd0);
  assign bus.inst_out    = head.inst;
  assign bus.inst_pc     = head.pc;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle-scripted stimulus thread queues the
// PCs decode should accept, and a monitor checks every accepted word in order.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [31:0] exp_q[$];

  fetch_if bus();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C00_0000 ^ ({25'd0, a[6:2], 2'b00} * 32'h0001_0003);
  endfunction

  // Single-cycle-latency instruction memory of 32 words.
  always @(posedge clk)
    if (bus.imem_rd) bus.imem_data <= mem_word(bus.imem_addr);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_flag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic ready, input logic hlt, input logic rv, input logic [31:0] rpc);
    bus.inst_ready     = ready;
    bus.halt           = hlt;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_range(input int unsigned first, input int unsigned last);
    for (int unsigned p = first; p <= last; p += 4) exp_q.push_back(32'(p));
  endtask

  task automatic check_reset_values();
    check_output("rst_imem_addr", bus.imem_addr, 32'h0);
    check_flag("rst_imem_rd", bus.imem_rd, 1'b0);
    check_flag("rst_inst_valid", bus.inst_valid, 1'b0);
    check_output("rst_inst_out", bus.inst_out, 32'h0);
    check_output("rst_inst_pc", bus.inst_pc, 32'h0);
    check_flag("rst_fetch_fault", bus.fetch_fault, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Scoreboard monitor: every accepted word must be the next expected PC.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_xfer: got pc %h, expected no transfer (cycle %0d)", bus.inst_pc, cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check_output("xfer_pc", bus.inst_pc, e);
        check_output("xfer_inst", bus.inst_out, mem_word(e));
      end
    end
  end

  initial begin
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_reset_values();

    // Streaming from reset, backpressure, then running off the end of memory.
    release_reset();
    expect_range(0, 124);
    #1;
    check_flag("c0_imem_rd", bus.imem_rd, 1'b1);
    check_output("c0_imem_addr", bus.imem_addr, 32'h0);
    check_flag("c0_inst_valid", bus.inst_valid, 1'b0);
    goto_cycle(1); #1;
    check_flag("c1_inst_valid", bus.inst_valid, 1'b0);
    check_output("c1_imem_addr", bus.imem_addr, 32'h4);
    goto_cycle(2); #1;
    check_flag("c2_inst_valid", bus.inst_valid, 1'b1);
    check_output("c2_inst_pc", bus.inst_pc, 32'h0);

    goto_cycle(16);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 17; c <= 20; c++) begin
      goto_cycle(c); #1;
      check_flag("bp_imem_rd", bus.imem_rd, 1'b0);
      check_output("bp_imem_addr", bus.imem_addr, 32'h40);
      check_output("bp_inst_pc", bus.inst_pc, 32'h38);
      check_output("bp_inst_out", bus.inst_out, mem_word(32'h38));
    end
    goto_cycle(21);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check_flag("bp_release_rd", bus.imem_rd, 1'b1);
    check_output("bp_release_addr", bus.imem_addr, 32'h40);

    goto_cycle(37); #1;
    check_flag("end_no_issue", bus.imem_rd, 1'b0);
    check_output("end_addr", bus.imem_addr, 32'h80);
    check_flag("end_fault_not_yet", bus.fetch_fault, 1'b0);
    goto_cycle(38); #1;
    check_flag("end_fault", bus.fetch_fault, 1'b1);
    check_flag("end_drain_valid", bus.inst_valid, 1'b1);
    check_output("end_drain_pc", bus.inst_pc, 32'h7C);
    goto_cycle(39); #1;
    check_flag("end_drained", bus.inst_valid, 1'b0);
    check_flag("end_fault_hold", bus.fetch_fault, 1'b1);

    // Legal redirect clears the fault and restarts at 0.
    goto_cycle(40);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0);
    expect_range(0, 4);
    #1;
    check_flag("rd0_fault_still", bus.fetch_fault, 1'b1);
    check_flag("rd0_no_issue", bus.imem_rd, 1'b0);
    goto_cycle(41);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check_flag("rd0_fault_clear", bus.fetch_fault, 1'b0);
    check_flag("rd0_issue", bus.imem_rd, 1'b1);
    check_output("rd0_issue_addr", bus.imem_addr, 32'h0);
    goto_cycle(43); #1;
    check_flag("rd0_valid", bus.inst_valid, 1'b1);
    check_output("rd0_pc", bus.inst_pc, 32'h0);

    // Redirect to 0x20 with 0x8 queued and 0xC in flight.
    goto_cycle(45);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h20);
    expect_range(32'h20, 32'h34);
    goto_cycle(46);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check_flag("r20_issue", bus.imem_rd, 1'b1);
    check_output("r20_addr", bus.imem_addr, 32'h20);
    check_flag("r20_flushed", bus.inst_valid, 1'b0);
    goto_cycle(47); #1;
    check_flag("r20_not_yet", bus.inst_valid, 1'b0);
    goto_cycle(48); #1;
    check_flag("r20_valid", bus.inst_valid, 1'b1);
    check_output("r20_pc", bus.inst_pc, 32'h20);

    // Halt for four cycles with a redirect to 0x10 inside it.
    goto_cycle(52);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1; check_flag("halt_c52_rd", bus.imem_rd, 1'b0);
    goto_cycle(53); #1; check_flag("halt_c53_rd", bus.imem_rd, 1'b0);
    goto_cycle(54);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h10);
    expect_range(32'h10, 32'h18);
    #1; check_flag("halt_c54_rd", bus.imem_rd, 1'b0);
    goto_cycle(55);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1; check_flag("halt_c55_rd", bus.imem_rd, 1'b0);
    goto_cycle(56);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check_flag("halt_release_rd", bus.imem_rd, 1'b1);
    check_output("halt_release_addr", bus.imem_addr, 32'h10);
    goto_cycle(58); #1;
    check_output("halt_first_pc", bus.inst_pc, 32'h10);

    // Misaligned redirect, accepted transfer of 0x18 in the same cycle.
    goto_cycle(60);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h6);
    goto_cycle(61);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check_flag("mis_fault", bus.fetch_fault, 1'b1);
    check_flag("mis_no_issue", bus.imem_rd, 1'b0);
    check_flag("mis_flushed", bus.inst_valid, 1'b0);
    check_output("mis_addr", bus.imem_addr, 32'h6);

    // Recover, stall decode, then reset with a read in flight.
    goto_cycle(64);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
    goto_cycle(65);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check_flag("rec_fault_clear", bus.fetch_fault, 1'b0);
    check_flag("rec_issue", bus.imem_rd, 1'b1);
    goto_cycle(67); #1;
    check_flag("pre_rst_rd", bus.imem_rd, 1'b0);
    check_output("pre_rst_addr", bus.imem_addr, 32'h8);
    check_flag("pre_rst_valid", bus.inst_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_values();

    repeat (2) @(posedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    release_reset();
    expect_range(0, 20);
    #1;
    check_flag("rst2_c0_rd", bus.imem_rd, 1'b1);
    check_output("rst2_c0_addr", bus.imem_addr, 32'h0);
    goto_cycle(2); #1;
    check_flag("rst2_valid", bus.inst_valid, 1'b1);
    check_output("rst2_pc", bus.inst_pc, 32'h0);
    goto_cycle(8);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    goto_cycle(10); #1;
    check_output("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
